// File: rtl/ddr_fb_pkg.sv
// Frame-buffer geometry shared by the DDR3 frame-buffer read/write blocks.
// Sizes are in 128-bit words (8 pixels of 16 bpp per word).
package ddr_fb_pkg;

    localparam int FB_H_WORDS      = 160;
    localparam int FB_V_LINES      = 720;
    localparam int FB_WORDS        = FB_H_WORDS * FB_V_LINES;
    localparam int ZOOM_WORDS      = (FB_H_WORDS / 2) * FB_V_LINES;
    localparam int ZOOM_MAX_X_WORD = FB_H_WORDS / 2;
    localparam int ZOOM_MAX_Y      = FB_V_LINES / 2;
    localparam int FB_ADDR_W       = 27;

    function automatic logic [11:0] clamp_u12(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/zoom_read_sequencer_evt_counter.sv
// Generic wrapping event counter: counts evt_i pulses from 0 to MAX_COUNT-1, then wraps.
// at_max_o is combinational so a TLAST derived from it has no extra latency.
module evt_counter #(
    parameter int WIDTH     = 27,
    parameter int MAX_COUNT = 57600
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             evt_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_max_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_max_o = (count_q == WIDTH'(MAX_COUNT - 1));
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (evt_i) begin
            count_d = at_max_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/zoom_read_sequencer.sv
// DDR3 read-address generator for 2x zoom: scans a half-size window of the frame buffer,
// reading every source line twice, and tracks response index, TLAST and outstanding reads.
module zoom_read_sequencer
    import ddr_fb_pkg::*;
#(
    parameter int H_WORDS = FB_H_WORDS,
    parameter int V_LINES = FB_V_LINES
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] zoom_view_x,
    input  logic [10:0] zoom_view_y,
    input  logic        req_evt,
    input  logic        resp_evt,
    output logic [26:0] req_addr,
    output logic [26:0] resp_index,
    output logic        resp_tlast,
    output logic [7:0]  outstanding,
    output logic        underflow_err
);

    localparam int COLS     = H_WORDS / 2;
    localparam int COL_W    = $clog2(COLS);
    localparam int LINE_W   = $clog2(V_LINES);
    localparam int MAX_XW   = H_WORDS / 2;
    localparam int MAX_Y    = V_LINES / 2;

    logic [COL_W-1:0]  req_col_q,  req_col_d;
    logic [LINE_W-1:0] req_line_q, req_line_d;
    logic [26:0]       row_base_q, row_base_d;
    logic [11:0]       x0_q,       x0_d;
    logic [7:0]        outstanding_q, outstanding_d;
    logic              underflow_q,   underflow_d;

    logic        col_last;
    logic        line_last;
    logic        at_origin;
    logic        frame_wrap;
    logic        load_win;
    logic [11:0] win_x0;
    logic [11:0] win_y0;
    logic [26:0] win_row_base;

    assign col_last   = (req_col_q == COL_W'(COLS - 1));
    assign line_last  = (req_line_q == LINE_W'(V_LINES - 1));
    assign at_origin  = (req_col_q == '0) && (req_line_q == '0);
    assign frame_wrap = req_evt && col_last && line_last;
    // The window is sampled while parked at the frame origin, so the first request
    // of a frame always sees zoom inputs from the previous cycle.
    assign load_win   = frame_wrap || (at_origin && !req_evt);

    assign win_x0       = clamp_u12(zoom_view_x >> 3, 12'(MAX_XW));
    assign win_y0       = clamp_u12({1'b0, zoom_view_y}, 12'(MAX_Y));
    assign win_row_base = 27'(win_y0) * 27'(H_WORDS);

    assign req_addr = row_base_q + 27'(x0_q) + 27'(req_col_q);

    always_comb begin
        req_col_d  = req_col_q;
        req_line_d = req_line_q;
        row_base_d = row_base_q;
        x0_d       = x0_q;
        if (req_evt) begin
            if (col_last) begin
                req_col_d = '0;
                if (line_last) begin
                    req_line_d = '0;
                end else begin
                    req_line_d = req_line_q + LINE_W'(1);
                    // Odd output line finished: both copies of this source line are done.
                    if (req_line_q[0]) begin
                        row_base_d = row_base_q + 27'(H_WORDS);
                    end
                end
            end else begin
                req_col_d = req_col_q + COL_W'(1);
            end
        end
        if (load_win) begin
            x0_d       = win_x0;
            row_base_d = win_row_base;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;
        if (resp_evt && (outstanding_q == '0)) begin
            underflow_d = 1'b1;
        end
        if (req_evt && !resp_evt) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (resp_evt && !req_evt && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            req_col_q     <= '0;
            req_line_q    <= '0;
            row_base_q    <= '0;
            x0_q          <= '0;
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            req_col_q     <= req_col_d;
            req_line_q    <= req_line_d;
            row_base_q    <= row_base_d;
            x0_q          <= x0_d;
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

    assign outstanding   = outstanding_q;
    assign underflow_err = underflow_q;

    evt_counter #(
        .WIDTH     (27),
        .MAX_COUNT (ZOOM_WORDS)
    ) u_resp_cnt (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .evt_i    (resp_evt),
        .count_o  (resp_index),
        .at_max_o (resp_tlast)
    );

endmodule

// File: tb/tb_zoom_read_sequencer.sv
// Scoreboard bench for zoom_read_sequencer: stimulus queues expected addresses/indices,
// a negedge monitor pops and compares them whenever req_evt/resp_evt is presented.
module tb_zoom_read_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [11:0] zoom_view_x;
    logic [10:0] zoom_view_y;
    logic        req_evt;
    logic        resp_evt;
    logic [26:0] req_addr;
    logic [26:0] resp_index;
    logic        resp_tlast;
    logic [7:0]  outstanding;
    logic        underflow_err;

    always #5 clk_in = ~clk_in;

    zoom_read_sequencer dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .zoom_view_x   (zoom_view_x),
        .zoom_view_y   (zoom_view_y),
        .req_evt       (req_evt),
        .resp_evt      (resp_evt),
        .req_addr      (req_addr),
        .resp_index    (resp_index),
        .resp_tlast    (resp_tlast),
        .outstanding   (outstanding),
        .underflow_err (underflow_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int exp_addr_q[$];
    int exp_idx_q[$];
    bit exp_tl_q[$];

    // Reference model state: request number within the frame, latched window, response index.
    int m_k, m_x0, m_y0, m_ridx;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic latch_window();
        int xw;
        xw   = int'(zoom_view_x) / 8;
        m_x0 = (xw > 80) ? 80 : xw;
        m_y0 = (int'(zoom_view_y) > 360) ? 360 : int'(zoom_view_y);
    endtask

    task automatic cycle(input bit rq, input bit rs);
        if (rq) exp_addr_q.push_back((m_y0 + (m_k / 80) / 2) * 160 + m_x0 + (m_k % 80));
        if (rs) begin
            exp_idx_q.push_back(m_ridx);
            exp_tl_q.push_back(m_ridx == 57599);
        end
        req_evt  = rq;
        resp_evt = rs;
        @(posedge clk_in);
        #1;
        req_evt  = 1'b0;
        resp_evt = 1'b0;
        if (rq) begin
            m_k++;
            if (m_k == 57600) begin
                m_k = 0;
                latch_window();
            end
        end else if (m_k == 0) begin
            latch_window();
        end
        if (rs) m_ridx = (m_ridx + 1) % 57600;
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        req_evt  = 1'b0;
        resp_evt = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        m_k    = 0;
        m_x0   = 0;
        m_y0   = 0;
        m_ridx = 0;
    endtask

    int  e_addr;
    int  e_idx;
    bit  e_tl;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (req_evt) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL req_addr: unexpected request, got %0d", req_addr);
                end else begin
                    e_addr = exp_addr_q.pop_front();
                    chk("req_addr", longint'(req_addr), e_addr);
                end
            end
            if (resp_evt) begin
                if (exp_idx_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL resp_index: unexpected response, got %0d", resp_index);
                end else begin
                    e_idx = exp_idx_q.pop_front();
                    e_tl  = exp_tl_q.pop_front();
                    chk("resp_index", longint'(resp_index), e_idx);
                    chk("resp_tlast", longint'(resp_tlast), longint'(e_tl));
                end
            end
        end
    end

    initial begin
        zoom_view_x = 12'd0;
        zoom_view_y = 11'd0;
        rst_in      = 1'b1;
        req_evt     = 1'b0;
        resp_evt    = 1'b0;
        @(posedge clk_in);
        do_reset();
        chk("rst_req_addr",    req_addr, 0);
        chk("rst_resp_index",  resp_index, 0);
        chk("rst_resp_tlast",  resp_tlast, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_underflow",   underflow_err, 0);

        // Line doubling at window (0,0)
        cycle(0, 0);
        for (int i = 0; i < 170; i++) begin
            if (i == 79)  chk("line0_last",   req_addr, 79);
            if (i == 80)  chk("line1_repeat", req_addr, 0);
            if (i == 160) chk("req161_addr",  req_addr, 160);
            cycle(1, (i != 0));
        end
        cycle(0, 1);
        chk("drain_outstanding", outstanding, 0);

        // Outstanding bookkeeping
        for (int i = 0; i < 5; i++) cycle(1, 0);
        chk("out_after_5req", outstanding, 5);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1);
            chk("out_both", outstanding, 5);
        end
        for (int i = 0; i < 5; i++) cycle(0, 1);
        chk("out_after_5resp", outstanding, 0);
        chk("no_underflow_yet", underflow_err, 0);
        cycle(0, 1);
        chk("out_underflow_stays0", outstanding, 0);
        chk("underflow_set", underflow_err, 1);

        // Run to output line 300, then reset mid-frame
        for (int i = 0; i < 3; i++) cycle(1, 0);
        while (m_k < 24000) cycle(1, 1);
        chk("pre_rst_outstanding", outstanding, 3);
        chk("underflow_sticky", underflow_err, 1);
        zoom_view_x = 12'd640;
        zoom_view_y = 11'd360;
        do_reset();
        chk("midrst_req_addr",    req_addr, 0);
        chk("midrst_resp_index",  resp_index, 0);
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_underflow",   underflow_err, 0);
        cycle(0, 0);
        chk("win_640_360_first", req_addr, 57680);

        // Clamped window, full frame, mid-frame zoom change
        zoom_view_x = 12'd1279;
        zoom_view_y = 11'd719;
        cycle(0, 0);
        chk("clamp_first_addr", req_addr, 57680);
        cycle(1, 0);
        for (int i = 1; i < 57600; i++) begin
            if (i == 30000) begin
                zoom_view_x = 12'd8;
                zoom_view_y = 11'd1;
            end
            if (i == 57599) chk("frame_last_addr", req_addr, 115199);
            cycle(1, 1);
        end
        chk("tlast_index", resp_index, 57599);
        chk("tlast_high",  resp_tlast, 1);
        chk("wrap_first_addr", req_addr, 161);
        cycle(1, 1);
        chk("resp_wrap_index", resp_index, 0);
        chk("resp_wrap_tlast", resp_tlast, 0);
        chk("frame_outstanding", outstanding, 1);
        cycle(0, 1);
        chk("final_outstanding", outstanding, 0);
        chk("final_underflow",   underflow_err, 0);
        chk("final_resp_index",  resp_index, 1);

        chk("scoreboard_drained", exp_addr_q.size() + exp_idx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
